// File: rtl/operand_bank_reducer.sv
// rtl/operand_bank_reducer.sv - NCH-channel operand bank with a multi-cycle sum/xor/max/min reducer
module operand_bank_reducer #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  localparam int IDX_W = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [NCH-1:0]   wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [1:0]       mode,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [1:0]       MODE_SUM = 2'b00;
  localparam logic [1:0]       MODE_XOR = 2'b01;
  localparam logic [1:0]       MODE_MAX = 2'b10;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] acc_q;
  logic [1:0]       mode_q;
  logic             carry_q;
  logic [WIDTH-1:0] ops_q [NCH];
  logic [WIDTH-1:0] result_q;
  logic             ovf_q;
  logic             done_q;
  logic             busy_q;

  logic [WIDTH-1:0] cur_op;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] step_d;
  logic             step_carry;

  // Explicit mux keeps out-of-range indices (non power-of-two NCH) harmless.
  always_comb begin
    cur_op = '0;
    for (int i = 0; i < NCH; i++) begin
      if (idx_q == IDX_W'(i)) cur_op = ops_q[i];
    end
  end

  assign sum_w = {1'b0, acc_q} + {1'b0, cur_op};

  always_comb begin
    step_d     = '0;
    step_carry = 1'b0;
    case (mode_q)
      MODE_SUM: begin
        step_d     = sum_w[WIDTH-1:0];
        step_carry = sum_w[WIDTH];
      end
      MODE_XOR: step_d = acc_q ^ cur_op;
      MODE_MAX: step_d = (cur_op > acc_q) ? cur_op : acc_q;
      default:  step_d = (cur_op < acc_q) ? cur_op : acc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) ops_q[i] <= '0;
    end else if (wr_en && !busy_q) begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_sel[i]) ops_q[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      mode_q   <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q  <= mode;
            acc_q   <= (mode == 2'b11) ? {WIDTH{1'b1}} : '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= step_d;
          idx_q <= idx_q + IDX_W'(1);
          if (step_carry) carry_q <= 1'b1;
          if (idx_q == LAST_IDX) begin
            result_q <= step_d;
            ovf_q    <= carry_q | step_carry;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_operand_bank_reducer.sv
// tb/tb_operand_bank_reducer.sv - directed scoreboard bench for operand_bank_reducer
module tb_operand_bank_reducer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] wr_sel;
  logic [3:0] wr_data;
  logic [1:0] mode;
  logic       start;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       ovf;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int runs = 0;

  logic [4:0] sb [$];

  operand_bank_reducer #(.WIDTH(4), .NCH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_data (wr_data),
    .mode    (mode),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] sel, input logic [3:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0; wr_sel = '0; wr_data = '0;
  endtask

  task automatic load4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    wr(4'b0001, a);
    wr(4'b0010, b);
    wr(4'b0100, c);
    wr(4'b1000, d);
  endtask

  // mid: 0 none, 1 write ch0=1 during busy, 2 re-assert start during busy.
  // co_wr: write ch0=F on the start edge.
  task automatic run(input string tag, input logic [1:0] m, input logic [3:0] er,
                     input logic eo, input int mid, input bit co_wr);
    int n;
    logic [4:0] exp;
    @(negedge clk);
    mode = m; start = 1'b1;
    if (co_wr) begin wr_en = 1'b1; wr_sel = 4'b0001; wr_data = 4'hF; end
    sb.push_back({eo, er});
    runs++;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_data = '0;
    mode = ~m;
    n = 0;
    while (busy && n < 20) begin
      n++;
      if (n == 2 && mid == 1) begin wr_en = 1'b1; wr_sel = 4'b0001; wr_data = 4'h1; end
      if (n == 2 && mid == 2) start = 1'b1;
      if (n == 3) begin wr_en = 1'b0; wr_sel = '0; wr_data = '0; start = 1'b0; end
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, n, 4);
    chk({tag, "_done"}, done, 1'b1);
    if (done && sb.size() > 0) begin
      exp = sb.pop_front();
      chk({tag, "_result"}, result, exp[3:0]);
      chk({tag, "_ovf"}, ovf, exp[4]);
    end
    @(negedge clk);
    chk({tag, "_done_low"}, done, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_data = '0; mode = '0; start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 4'h0);
    chk("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;

    load4(4'h3, 4'h5, 4'h7, 4'h9);
    run("sum3579", 2'b00, 4'h8, 1'b1, 0, 1'b0);
    run("xor3579", 2'b01, 4'h8, 1'b0, 0, 1'b0);

    load4(4'h3, 4'hC, 4'h0, 4'h7);
    run("max", 2'b10, 4'hC, 1'b0, 0, 1'b0);
    run("min", 2'b11, 4'h0, 1'b0, 0, 1'b0);

    wr(4'b1111, 4'hA);
    run("bcast", 2'b00, 4'h8, 1'b1, 1, 1'b0);
    run("bcast_rerun", 2'b00, 4'h8, 1'b1, 0, 1'b0);

    load4(4'h1, 4'h2, 4'h3, 4'h4);
    run("restart_busy", 2'b00, 4'hA, 1'b0, 2, 1'b0);
    repeat (6) @(negedge clk);
    chk("no_queued_run", done_cnt, runs);

    // Reset aborts a reduction in flight.
    load4(4'h3, 4'h5, 4'h7, 4'h9);
    @(negedge clk);
    mode = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_result", result, 4'h0);
    chk("abort_ovf", ovf, 1'b0);
    repeat (8) @(negedge clk);
    chk("abort_no_done", done_cnt, runs);
    run("post_reset_sum", 2'b00, 4'h0, 1'b0, 0, 1'b0);

    run("cowrite_sum", 2'b00, 4'hF, 1'b0, 0, 1'b1);
    run("cowrite_min", 2'b11, 4'h0, 1'b0, 0, 1'b0);

    repeat (3) @(negedge clk);
    chk("done_count", done_cnt, runs);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_bank_reducer.md
Name: operand_bank_reducer

Overview:
- Parametrised successor to the fixed four-nibble operand loader.
- Holds NCH operand registers of WIDTH bits each, loaded from a shared data bus under a per-channel select mask.
- On a start request, a multi-cycle sequencer walks all channels once and reduces them with a selectable operator (sum, xor, max, min).
- Publishes a registered result, an overflow flag and a one-cycle done pulse; sits between the top-level pin mapping and the display/output logic.

Parameters:
- WIDTH, 4: operand and result width in bits; legal range 1 and up.
- NCH, 4: number of operand channels; legal range 2 and up.
- IDX_W, $clog2(NCH): width of the internal channel index; derived, not overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- wr_en  in  1  operand write enable
- wr_sel  in  NCH  channel select mask; bit i selects operand i
- wr_data  in  WIDTH  operand write data
- mode  in  2  reduction operator: 00 sum, 01 xor, 10 unsigned max, 11 unsigned min
- start  in  1  start request; sampled only while idle
- busy  out  1  high while a reduction is in progress
- done  out  1  one-cycle pulse when result/ovf update
- result  out  WIDTH  last completed reduction result
- ovf  out  1  sum-mode carry-out flag for the last completed reduction

Behaviour:
- Reset (rst_n low at a clk edge):
  - all operand registers, result, ovf, done, busy and the index clear to 0;
  - state goes to IDLE;
  - reset has priority over every other input.
- Operand write: at a clk edge with wr_en=1 and busy=0, every operand i with wr_sel[i]=1 loads wr_data.
  - Multiple set bits broadcast the same value.
  - wr_sel=0 writes nothing.
  - Writes are ignored while busy=1.
- States: IDLE, RUN.
- IDLE:
  - start=1 at an edge: latch mode into an internal mode register, set acc to the operator identity, set idx=0, set busy=1, go to RUN.
  - Identities: sum 0, xor 0, max 0, min all-ones.
  - A write coincident with start is committed and is visible to the reduction.
- RUN, each edge:
  - acc <= op(acc, operand[idx]);
  - idx <= idx+1;
  - in sum mode, a carry-out at any step sets an internal sticky carry bit.
- Last RUN step (idx = NCH-1), at that edge:
  - result <= op(acc, operand[NCH-1]);
  - ovf <= sticky carry, or carry of this final step (0 in non-sum modes);
  - done <= 1, busy <= 0, go to IDLE.
- Sum arithmetic: sum wraps modulo 2^WIDTH. max/min compare unsigned.
- Latency, with the start edge as E0:
  - busy is high for exactly NCH cycles (from after E0 until E_NCH);
  - done is high for the single cycle after E_NCH;
  - result/ovf are valid in the same cycle done is high.
- done is high for exactly one cycle per completed reduction and is 0 at all other times.
- result and ovf hold their values until the next completion; they are not cleared by start.
- start while busy=1 is ignored; it is not queued.
- start held high continuously:
  - a new reduction begins on the first idle edge, i.e. the edge where done is high;
  - back-to-back reductions therefore start every NCH+1 cycles.
- mode changes during RUN have no effect; the latched mode is used.
- Reset mid-RUN aborts the reduction: no done pulse, and result/ovf clear to 0.

Test Plan:
- WIDTH=4, NCH=4; write 3,5,7,9 to ch0..3; mode=00; pulse start -> busy high 4 cycles; done pulses at cycle 5; result=8 (24 mod 16), ovf=1.
- Same operands, mode=01 -> result=8 (3^5^7^9), ovf=0. Operands 3,C,0,7: mode=10 -> result=C; mode=11 -> result=0.
- wr_sel=1111, wr_data=A (broadcast); mode=00; start -> result=8, ovf=1. During busy, write wr_sel=0001, data=1 -> ignored; rerun gives result=8 again.
- Operands 1,2,3,4; mode=00; start; assert start again at busy cycle 2 -> single done pulse, result=A, ovf=0; no second run queued.
- Start reduction of 3,5,7,9; assert rst_n=0 at busy cycle 2 -> next cycle busy=0, done never pulses, result=0, ovf=0, all operands read back 0 (rerun sum yields 0).
- start and write (wr_sel=0001, data=F) on the same edge with others 0 -> reduction uses F; sum result=F, ovf=0; mode=11 with same data -> result=0.
